// File: rtl/pll_pkg.sv
// Shared constants and types for the BPSK loopback transmitter and the Costas receiver.
package pll_pkg;

   localparam int unsigned PHASE_W     = 32;
   localparam int unsigned SAMPLE_W    = 8;
   localparam int unsigned LUT_ADDR_W  = 6;
   localparam int unsigned AMP_MAX     = 127;
   localparam int unsigned LUT_PHASE_W = LUT_ADDR_W + 2;

   // Carrier word shared with the receiver NCO initial programming (fs/8).
   localparam logic [PHASE_W-1:0] FREQ_INITIAL = 32'h2000_0000;

   typedef enum logic [0:0] {
      TX_IDLE   = 1'b0,
      TX_ACTIVE = 1'b1
   } tx_state_e;

   // Stage-1 payload of the modulation pipeline.
   typedef struct packed {
      logic                vld;
      logic                neg;
      logic [SAMPLE_W-1:0] sine;
   } tx_stage_t;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM (65 entries) with quadrant folding; 8-bit phase in, signed 8-bit sine out.
module sine_quarter_lut
   import pll_pkg::*;
(
   input  logic [LUT_PHASE_W-1:0] phase_i,
   output logic [SAMPLE_W-1:0]    sine_o
);

   localparam int unsigned MAG_W = SAMPLE_W - 1;
   localparam int unsigned IDX_W = LUT_ADDR_W + 1;

   logic [1:0]            quad;
   logic [LUT_ADDR_W-1:0] idx;
   logic [IDX_W-1:0]      addr;
   logic [MAG_W-1:0]      mag;

   assign quad = phase_i[LUT_PHASE_W-1 -: 2];
   assign idx  = phase_i[LUT_ADDR_W-1:0];

   // Odd quadrants read the table backwards from the peak entry.
   assign addr = quad[0] ? (IDX_W'(1 << LUT_ADDR_W) - IDX_W'(idx)) : IDX_W'(idx);

   // L[k] = round(127*sin(2*pi*k/256)), k = 0..64
   always_comb begin
      mag = '0;
      case (addr)
         7'd0:  mag = 7'd0;    7'd1:  mag = 7'd3;    7'd2:  mag = 7'd6;    7'd3:  mag = 7'd9;
         7'd4:  mag = 7'd12;   7'd5:  mag = 7'd16;   7'd6:  mag = 7'd19;   7'd7:  mag = 7'd22;
         7'd8:  mag = 7'd25;   7'd9:  mag = 7'd28;   7'd10: mag = 7'd31;   7'd11: mag = 7'd34;
         7'd12: mag = 7'd37;   7'd13: mag = 7'd40;   7'd14: mag = 7'd43;   7'd15: mag = 7'd46;
         7'd16: mag = 7'd49;   7'd17: mag = 7'd51;   7'd18: mag = 7'd54;   7'd19: mag = 7'd57;
         7'd20: mag = 7'd60;   7'd21: mag = 7'd63;   7'd22: mag = 7'd65;   7'd23: mag = 7'd68;
         7'd24: mag = 7'd71;   7'd25: mag = 7'd73;   7'd26: mag = 7'd76;   7'd27: mag = 7'd78;
         7'd28: mag = 7'd81;   7'd29: mag = 7'd83;   7'd30: mag = 7'd85;   7'd31: mag = 7'd88;
         7'd32: mag = 7'd90;   7'd33: mag = 7'd92;   7'd34: mag = 7'd94;   7'd35: mag = 7'd96;
         7'd36: mag = 7'd98;   7'd37: mag = 7'd100;  7'd38: mag = 7'd102;  7'd39: mag = 7'd104;
         7'd40: mag = 7'd106;  7'd41: mag = 7'd107;  7'd42: mag = 7'd109;  7'd43: mag = 7'd111;
         7'd44: mag = 7'd112;  7'd45: mag = 7'd113;  7'd46: mag = 7'd115;  7'd47: mag = 7'd116;
         7'd48: mag = 7'd117;  7'd49: mag = 7'd118;  7'd50: mag = 7'd120;  7'd51: mag = 7'd121;
         7'd52: mag = 7'd122;  7'd53: mag = 7'd122;  7'd54: mag = 7'd123;  7'd55: mag = 7'd124;
         7'd56: mag = 7'd125;  7'd57: mag = 7'd125;  7'd58: mag = 7'd126;  7'd59: mag = 7'd126;
         7'd60: mag = 7'd126;  7'd61: mag = 7'd127;  7'd62: mag = 7'd127;  7'd63: mag = 7'd127;
         7'd64: mag = MAG_W'(AMP_MAX);
         default: mag = '0;
      endcase
   end

   // Lower half-cycle is the negated magnitude; range stays within -127..127.
   assign sine_o = quad[1] ? (SAMPLE_W'(0) - {1'b0, mag}) : {1'b0, mag};

endmodule

// File: rtl/bpsk_tx.sv
// BPSK transmitter: bit handshake FSM, continuous-phase carrier NCO and 2-stage modulation pipeline.
module bpsk_tx
   import pll_pkg::*;
#(
   parameter int unsigned        SPS        = 16,
   parameter logic [PHASE_W-1:0] FREQ_WORD  = FREQ_INITIAL,
   parameter logic [PHASE_W-1:0] PHASE_INIT = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                bit_valid,
   input  logic                bit_data,
   output logic                bit_ready,
   output logic [SAMPLE_W-1:0] dout,
   output logic                dout_valid,
   output logic                busy
);

   localparam int unsigned      CNT_W    = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

   tx_state_e           state_q, state_d;
   logic [PHASE_W-1:0]  phase_q, phase_d;
   logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
   logic                cur_bit_q, cur_bit_d;
   tx_stage_t           s1_q, s1_d;
   logic [SAMPLE_W-1:0] dout_q, dout_d;
   logic                dout_valid_q;
   logic                issue_c;
   logic                ready_c;
   logic [SAMPLE_W-1:0] lut_sine;

   // Control and carrier state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= TX_IDLE;
         phase_q   <= PHASE_INIT;
         sym_cnt_q <= '0;
         cur_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         sym_cnt_q <= sym_cnt_d;
         cur_bit_q <= cur_bit_d;
      end
   end

   // Phase accumulator: free-running while enabled, never reloaded outside reset
   always_comb begin
      phase_d = phase_q;
      if (enable) begin
         phase_d = phase_q + FREQ_WORD;
      end
   end

   // Symbol FSM: bit acceptance, per-sample issue and symbol counting
   always_comb begin
      state_d   = state_q;
      sym_cnt_d = sym_cnt_q;
      cur_bit_d = cur_bit_q;
      issue_c   = 1'b0;
      ready_c   = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            ready_c = enable;
            if (enable && bit_valid) begin
               cur_bit_d = bit_data;
               sym_cnt_d = '0;
               state_d   = TX_ACTIVE;
            end
         end
         TX_ACTIVE: begin
            if (!enable) begin
               // Partial symbol is abandoned; nothing issued this cycle.
               state_d = TX_IDLE;
            end else begin
               issue_c = 1'b1;
               if (sym_cnt_q == CNT_LAST) begin
                  ready_c   = 1'b1;
                  sym_cnt_d = '0;
                  if (bit_valid) begin
                     cur_bit_d = bit_data;
                  end else begin
                     state_d = TX_IDLE;
                  end
               end else begin
                  sym_cnt_d = sym_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   sine_quarter_lut u_lut (
      .phase_i (phase_q[PHASE_W-1 -: LUT_PHASE_W]),
      .sine_o  (lut_sine)
   );

   // Pipeline next-state: stage 1 captures the carrier sample, stage 2 applies the data sign
   always_comb begin
      s1_d      = '0;
      s1_d.vld  = issue_c;
      s1_d.neg  = cur_bit_q;
      if (issue_c) begin
         s1_d.sine = lut_sine;
      end
      dout_d = '0;
      if (s1_q.vld) begin
         dout_d = s1_q.neg ? (SAMPLE_W'(0) - s1_q.sine) : s1_q.sine;
      end
   end

   // Pipeline registers; in-flight samples drain regardless of enable or state
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q         <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         s1_q         <= s1_d;
         dout_q       <= dout_d;
         dout_valid_q <= s1_q.vld;
      end
   end

   assign bit_ready  = ready_c & ~rst;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = (state_q == TX_ACTIVE);

endmodule
